// File: rtl/bfly_rnd_fac8_3_pkg.sv
// fft_pkg: shared widths and sample types for the radix-2 round/saturate
// butterfly stage (bfly_rnd_fac8_3).
//   LANES       lanes per group
//   DIN_WIDTH   twiddled product width, format <10.13>
//   FRAC_DROP   fractional bits removed by rounding
//   MID_WIDTH   rounded/saturated width, format <8.6>
//   DOUT_WIDTH  butterfly output width, format <9.6>
//   BEATS       beats per 512-point frame
package fft_pkg;
  localparam int LANES      = 16;
  localparam int DIN_WIDTH  = 23;
  localparam int FRAC_DROP  = 7;
  localparam int MID_WIDTH  = 14;
  localparam int DOUT_WIDTH = MID_WIDTH + 1;
  localparam int BEATS      = 8;

  typedef logic signed [DIN_WIDTH-1:0]  prod_t;
  typedef logic signed [MID_WIDTH-1:0]  mid_t;
  typedef logic signed [DOUT_WIDTH-1:0] dout_t;
endpackage

// File: rtl/bfly_rnd_fac8_3_if.sv
// Bus interface for bfly_rnd_fac8_3.
//   din_valid + din_{r,q}_{add,sub}[LANES]   : products from the multiplier
//   dout_valid + dout_{r,q}_{add,sub}[LANES] : butterfly results
//   beat_idx, frame_last, sat_flag           : frame bookkeeping on the output
// master: producer/consumer side (drives din_*, observes dout_*)
// slave : the butterfly block
interface bfly_rnd_fac8_3_if;
  import fft_pkg::*;

  logic  din_valid;
  prod_t din_r_add [LANES];
  prod_t din_q_add [LANES];
  prod_t din_r_sub [LANES];
  prod_t din_q_sub [LANES];

  logic  dout_valid;
  dout_t dout_r_add [LANES];
  dout_t dout_q_add [LANES];
  dout_t dout_r_sub [LANES];
  dout_t dout_q_sub [LANES];
  logic [2:0] beat_idx;
  logic  frame_last;
  logic  sat_flag;

  modport master (
    output din_valid, din_r_add, din_q_add, din_r_sub, din_q_sub,
    input  dout_valid, dout_r_add, dout_q_add, dout_r_sub, dout_q_sub,
    input  beat_idx, frame_last, sat_flag
  );

  modport slave (
    input  din_valid, din_r_add, din_q_add, din_r_sub, din_q_sub,
    output dout_valid, dout_r_add, dout_q_add, dout_r_sub, dout_q_sub,
    output beat_idx, frame_last, sat_flag
  );
endinterface

// File: rtl/bfly_rnd_fac8_3_rnd_sat.sv
// rnd_sat: one combinational lane of round-half-up followed by saturation
// (or two's-complement wrap) down to MID_WIDTH bits.
//   din   : signed product, DIN_WIDTH bits
//   r     : rounded value, MID_WIDTH bits
//   clamp : high when r was clamped (always 0 without saturation)
// Optional feature: BFLY_RND_SAT_EN enables clamping and the clamp flag.
module rnd_sat #(
  parameter int DIN_WIDTH = fft_pkg::DIN_WIDTH,
  parameter int FRAC_DROP = fft_pkg::FRAC_DROP,
  parameter int MID_WIDTH = fft_pkg::MID_WIDTH
) (
  input  logic signed [DIN_WIDTH-1:0] din,
  output logic signed [MID_WIDTH-1:0] r,
  output logic                        clamp
);
  localparam logic signed [DIN_WIDTH:0] HALF = (DIN_WIDTH+1)'(1) <<< (FRAC_DROP-1);

  // One guard bit keeps din + HALF from overflowing at the top of the range.
  function automatic logic signed [DIN_WIDTH:0] round_hu(input logic signed [DIN_WIDTH-1:0] x);
    logic signed [DIN_WIDTH:0] s;
    s = (DIN_WIDTH+1)'(x) + HALF;
    return s >>> FRAC_DROP;
  endfunction

  logic signed [DIN_WIDTH:0] rounded;
  assign rounded = round_hu(din);

`ifdef BFLY_RND_SAT_EN
  localparam logic signed [DIN_WIDTH:0] MAXV = (DIN_WIDTH+1)'((1 <<< (MID_WIDTH-1)) - 1);
  localparam logic signed [DIN_WIDTH:0] MINV = -((DIN_WIDTH+1)'(1) <<< (MID_WIDTH-1));

  function automatic logic signed [MID_WIDTH-1:0] saturate(input logic signed [DIN_WIDTH:0] v);
    if (v > MAXV)      return MID_WIDTH'(MAXV);
    else if (v < MINV) return MID_WIDTH'(MINV);
    else               return MID_WIDTH'(v);
  endfunction

  assign r     = saturate(rounded);
  assign clamp = (rounded > MAXV) || (rounded < MINV);
`else
  assign r     = MID_WIDTH'(rounded);
  assign clamp = 1'b0;
`endif
endmodule

// File: rtl/bfly_rnd_fac8_3.sv
// bfly_rnd_fac8_3: two-stage pipeline that rounds (and optionally saturates)
// four arrays of twiddled products, then applies a radix-2 butterfly within
// each array (lane i pairs with lane i+LANES/2). Latency is exactly 2 cycles,
// no backpressure. Tracks the beat index within an 8-beat frame and a sticky
// per-frame saturation flag.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bfly_rnd_fac8_3_if.slave (din_* in, dout_*/beat_idx/frame_last/sat_flag out)
// Optional feature: BFLY_RND_SAT_EN (clamping + sat_flag; without it the
// rounded value wraps and sat_flag stays 0).
module bfly_rnd_fac8_3 #(
  parameter int LANES      = fft_pkg::LANES,
  parameter int DIN_WIDTH  = fft_pkg::DIN_WIDTH,
  parameter int FRAC_DROP  = fft_pkg::FRAC_DROP,
  parameter int MID_WIDTH  = fft_pkg::MID_WIDTH,
  parameter int DOUT_WIDTH = MID_WIDTH + 1,
  parameter int BEATS      = fft_pkg::BEATS
) (
  input logic               clk,
  input logic               rst,
  bfly_rnd_fac8_3_if.slave  bus
);
  localparam int         HALF_L    = LANES / 2;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  // Arrays indexed 0..3 = r_add, q_add, r_sub, q_sub.
  logic signed [DIN_WIDTH-1:0]  din_arr [4][LANES];
  logic signed [MID_WIDTH-1:0]  r_c     [4][LANES];
  logic                         clamp_c [4][LANES];
  logic                         any_clamp;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      din_arr[0][l] = bus.din_r_add[l];
      din_arr[1][l] = bus.din_q_add[l];
      din_arr[2][l] = bus.din_r_sub[l];
      din_arr[3][l] = bus.din_q_sub[l];
    end
  end

  for (genvar a = 0; a < 4; a++) begin : g_arr
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      rnd_sat #(
        .DIN_WIDTH (DIN_WIDTH),
        .FRAC_DROP (FRAC_DROP),
        .MID_WIDTH (MID_WIDTH)
      ) u_rnd_sat (
        .din   (din_arr[a][l]),
        .r     (r_c[a][l]),
        .clamp (clamp_c[a][l])
      );
    end
  end

  always_comb begin
    any_clamp = 1'b0;
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < LANES; l++)
        any_clamp = any_clamp | clamp_c[a][l];
  end

  // ---- stage 1: rounded/saturated values ----
  logic signed [MID_WIDTH-1:0] r_p0 [4][LANES];
  logic                        vld_p0;
  logic                        sat_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sat_p0 <= 1'b0;
      for (int a = 0; a < 4; a++)
        for (int l = 0; l < LANES; l++)
          r_p0[a][l] <= '0;
    end else begin
      vld_p0 <= bus.din_valid;
      if (bus.din_valid) begin
        r_p0   <= r_c;
        sat_p0 <= any_clamp;
      end
    end
  end

  // ---- stage 2: butterfly and frame bookkeeping ----
  logic signed [DOUT_WIDTH-1:0] dout_p1 [4][LANES];
  logic                         vld_p1;
  logic [2:0]                   beat_cnt;
  logic [2:0]                   beat_idx_p1;
  logic                         frame_last_p1;
  logic                         sat_flag_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      beat_cnt      <= '0;
      beat_idx_p1   <= '0;
      frame_last_p1 <= 1'b0;
      sat_flag_p1   <= 1'b0;
      for (int a = 0; a < 4; a++)
        for (int l = 0; l < LANES; l++)
          dout_p1[a][l] <= '0;
    end else begin
      vld_p1        <= vld_p0;
      frame_last_p1 <= vld_p0 && (beat_cnt == LAST_BEAT);
      if (vld_p0) begin
        for (int a = 0; a < 4; a++) begin
          for (int i = 0; i < HALF_L; i++) begin
            dout_p1[a][i]        <= DOUT_WIDTH'(r_p0[a][i]) + DOUT_WIDTH'(r_p0[a][i+HALF_L]);
            dout_p1[a][i+HALF_L] <= DOUT_WIDTH'(r_p0[a][i]) - DOUT_WIDTH'(r_p0[a][i+HALF_L]);
          end
        end
        beat_idx_p1 <= beat_cnt;
        beat_cnt    <= (beat_cnt == LAST_BEAT) ? 3'd0 : beat_cnt + 3'd1;
        // Beat 0 restarts the sticky flag with its own status so a
        // saturation on the first beat of a frame is not dropped.
        sat_flag_p1 <= (beat_cnt == 3'd0) ? sat_p0 : (sat_flag_p1 | sat_p0);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      bus.dout_r_add[l] = dout_p1[0][l];
      bus.dout_q_add[l] = dout_p1[1][l];
      bus.dout_r_sub[l] = dout_p1[2][l];
      bus.dout_q_sub[l] = dout_p1[3][l];
    end
  end

  assign bus.dout_valid = vld_p1;
  assign bus.beat_idx   = beat_idx_p1;
  assign bus.frame_last = frame_last_p1;
  assign bus.sat_flag   = sat_flag_p1;
endmodule

// File: tb/tb_bfly_rnd_fac8_3.sv
// Testbench for bfly_rnd_fac8_3: random and directed beats checked against a
// behavioural model (queue of expected output beats), plus literal checks.
// Honours BFLY_RND_SAT_EN in the model.
module tb_bfly_rnd_fac8_3;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  bfly_rnd_fac8_3_if bus();

  bfly_rnd_fac8_3 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int due;
    int d[4][16];
    int idx;
    int last;
    int sat;
  } exp_t;

  exp_t q[$];
  int   stim[4][16];
  int   m_beat;
  int   m_sat;

`ifdef BFLY_RND_SAT_EN
  localparam int SAT_ON = 1;
`else
  localparam int SAT_ON = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round half up (floor of (x+64)/128), then clamp or wrap to 14 bits.
  function automatic int rnd_model(input int x, output int c);
    int s, f;
    s = x + 64;
    f = (s >= 0) ? s / 128 : -((-s + 127) / 128);
    c = 0;
`ifdef BFLY_RND_SAT_EN
    if (f > 8191)       begin f = 8191;  c = 1; end
    else if (f < -8192) begin f = -8192; c = 1; end
`else
    f = f & 16383;
    if (f >= 8192) f = f - 16384;
`endif
    return f;
  endfunction

  function automatic int dout_get(input int a, input int l);
    case (a)
      0:       return int'(bus.dout_r_add[l]);
      1:       return int'(bus.dout_q_add[l]);
      2:       return int'(bus.dout_r_sub[l]);
      default: return int'(bus.dout_q_sub[l]);
    endcase
  endfunction

  task automatic set_din(input int a, input int l, input int v);
    case (a)
      0:       bus.din_r_add[l] = prod_t'(v);
      1:       bus.din_q_add[l] = prod_t'(v);
      2:       bus.din_r_sub[l] = prod_t'(v);
      default: bus.din_q_sub[l] = prod_t'(v);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < 16; l++)
        stim[a][l] = 0;
  endtask

  function automatic int rand_din();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return int'($urandom_range(0, 8388607)) - 4194304;
    if (k == 1) begin
      case ($urandom_range(0, 3))
        0:       return 1048511;
        1:       return 1048512;
        2:       return -1048640;
        default: return -1048641;
      endcase
    end
    return int'($urandom_range(0, 1048576)) - 524288;
  endfunction

  task automatic rand_stim();
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < 16; l++)
        stim[a][l] = rand_din();
  endtask

  // Drive one valid beat from stim (called just after a rising edge) and
  // record what must appear two cycles later.
  task automatic send();
    exp_t e;
    int   r[4][16];
    int   c, any;
    any = 0;
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < 16; l++) begin
        r[a][l] = rnd_model(stim[a][l], c);
        any = any | c;
        set_din(a, l, stim[a][l]);
      end
    for (int a = 0; a < 4; a++)
      for (int i = 0; i < 8; i++) begin
        e.d[a][i]   = r[a][i] + r[a][i+8];
        e.d[a][i+8] = r[a][i] - r[a][i+8];
      end
    e.idx  = m_beat;
    e.last = (m_beat == 7) ? 1 : 0;
    m_sat  = (m_beat == 0) ? any : (m_sat | any);
    e.sat  = m_sat;
    m_beat = (m_beat + 1) % 8;
    e.due  = cyc + 2;
    q.push_back(e);
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
  endtask

  // Single beat on lane0/lane8 of r_add, checked literally 2 cycles later.
  task automatic send_check(input int v0, input int v8, input int e0, input int e8,
                            input string name);
    clear_stim();
    stim[0][0] = v0;
    stim[0][8] = v8;
    send();
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, int'(bus.dout_valid), 1);
    check({name, "_add0"},  int'(bus.dout_r_add[0]), e0);
    check({name, "_add8"},  int'(bus.dout_r_add[8]), e8);
  endtask

  task automatic reset_model();
    q.delete();
    m_beat = 0;
    m_sat  = 0;
  endtask

  // Compare process: every cycle, against the model queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("rst_valid",  int'(bus.dout_valid), 0);
      check("rst_beat",   int'(bus.beat_idx), 0);
      check("rst_last",   int'(bus.frame_last), 0);
      check("rst_sat",    int'(bus.sat_flag), 0);
      check("rst_data",   int'(bus.dout_q_sub[15]), 0);
    end else if (q.size() > 0 && q[0].due < cyc) begin
      check("lost_beat", q[0].due, cyc);
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      check("dout_valid", int'(bus.dout_valid), 1);
      for (int a = 0; a < 4; a++) begin
        int bad;
        bad = 0;
        for (int l = 0; l < 16; l++)
          if (dout_get(a, l) != e.d[a][l]) begin
            bad = l;
            break;
          end
        check($sformatf("dout_arr%0d_lane%0d", a, bad), dout_get(a, bad), e.d[a][bad]);
      end
      check("beat_idx",   int'(bus.beat_idx), e.idx);
      check("frame_last", int'(bus.frame_last), e.last);
      check("sat_flag",   int'(bus.sat_flag), e.sat);
    end else begin
      check("idle_valid", int'(bus.dout_valid), 0);
      check("idle_last",  int'(bus.frame_last), 0);
    end
  end

  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    clear_stim();
    for (int a = 0; a < 4; a++)
      for (int l = 0; l < 16; l++)
        set_din(a, l, 0);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Rounding boundaries, beats 0..3 of frame 0.
    send_check(64,  0, 1, 1, "rnd_64");
    check("first_beat_idx", int'(bus.beat_idx), 0);
    send_check(63,  0, 0, 0, "rnd_63");
    send_check(-64, 0, 0, 0, "rnd_m64");
    send_check(-65, 0, -1, -1, "rnd_m65");
    // Butterfly: 100 and 30 after rounding.
    send_check(100*128, 30*128, 130, 70, "bfly");
    // Saturating beat 5 of the frame.
    if (SAT_ON != 0) send_check(4194303, 0, 8191, 8191, "sat_max");
    else             send_check(4194303, 0, 0, 0, "wrap_max");
    check("beat5_idx", int'(bus.beat_idx), 5);
    check("beat5_sat", int'(bus.sat_flag), SAT_ON);
    send_check(0, 0, 0, 0, "beat6");
    send_check(0, 0, 0, 0, "beat7");
    check("beat7_last", int'(bus.frame_last), 1);
    check("beat7_sat",  int'(bus.sat_flag), SAT_ON);
    // New frame without saturation: flag restarts at beat 0.
    send_check(128, 0, 1, 1, "nf_beat0");
    check("nf_beat_idx", int'(bus.beat_idx), 0);
    check("nf_sat",      int'(bus.sat_flag), 0);
    check("nf_last",     int'(bus.frame_last), 0);

    // Random beats with random gaps.
    for (int n = 0; n < 60; n++) begin
      rand_stim();
      send();
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset with beats in flight, mid-frame.
    repeat (3) begin
      rand_stim();
      send();
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(bus.dout_valid), 0);
    check("midrst_beat",  int'(bus.beat_idx), 0);
    check("midrst_sat",   int'(bus.sat_flag), 0);
    check("midrst_data",  int'(bus.dout_r_add[0]), 0);
    reset_model();
    step();
    step();
    rst = 1'b0;
    step();
    send_check(256, 0, 2, 2, "post_rst");
    check("post_rst_idx", int'(bus.beat_idx), 0);
    check("post_rst_sat", int'(bus.sat_flag), 0);

    for (int n = 0; n < 40; n++) begin
      rand_stim();
      send();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    check("drain_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d, expected finish earlier", cyc);
    $fatal(1, "timeout");
  end
endmodule
